// File: rtl/time_set_pkg.sv
// Shared types and constants for the time/alarm entry controller:
// FSM state encoding, per-digit wrap limits and digit indices.
package time_set_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EDIT_H1 = 3'd1,
    S_EDIT_H0 = 3'd2,
    S_EDIT_M1 = 3'd3,
    S_EDIT_M0 = 3'd4,
    S_COMMIT  = 3'd5
  } state_e;

  // Largest legal value of each digit; incrementing past it wraps to 0.
  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;  // hour units limit once hour tens is 2
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  // Index reported on edit_digit.
  localparam logic [1:0] DIG_H1 = 2'd0;
  localparam logic [1:0] DIG_H0 = 2'd1;
  localparam logic [1:0] DIG_M1 = 2'd2;
  localparam logic [1:0] DIG_M0 = 2'd3;

  // Increment a BCD digit, wrapping to 0 once it has reached its limit.
  function automatic logic [3:0] bcd_bump(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? 4'd0 : v + 4'd1;
  endfunction

  // Digit index shown for a given state; non-edit states report 0.
  function automatic logic [1:0] digit_of(input state_e s);
    case (s)
      S_EDIT_H0: return DIG_H0;
      S_EDIT_M1: return DIG_M1;
      S_EDIT_M0: return DIG_M0;
      default:   return DIG_H1;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button front end: 2-FF synchronizer, stability-counter debouncer and a
// one-cycle press pulse on each accepted 0->1 transition.
// Optional macro TIME_SET_AUTOREPEAT_EN: instances built with REPEAT_EN=1
// also pulse while held (first repeat after 4*REPEAT_CYCLES, then every
// REPEAT_CYCLES).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_W = $clog2(4 * REPEAT_CYCLES + 1);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam bit AR_BUILD = 1'b1;
`else
  localparam bit AR_BUILD = 1'b0;
`endif

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rise, rep_fire;
  logic             press_q;

  // Accept a new level only after it has differed from the debounced one
  // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    rise  = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
        rise = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold-to-repeat timer: reloaded with the long initial delay while released.
  always_comb begin
    rep_d    = REP_W'(4 * REPEAT_CYCLES - 1);
    rep_fire = 1'b0;
    if (AR_BUILD && REPEAT_EN && db_q && db_d) begin
      if (rep_q == '0) begin
        rep_fire = 1'b1;
        rep_d    = REP_W'(REPEAT_CYCLES - 1);
      end else begin
        rep_d = rep_q - 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= REP_W'(4 * REPEAT_CYCLES - 1);
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      press_q <= rise | rep_fire;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven HH:MM entry controller for the alarm clock's load interface.
// Walks the four BCD digits with per-digit wrap limits, then strobes
// load_time or load_alarm for one cycle. Idle edits abort after
// TIMEOUT_CYCLES. Optional macro TIME_SET_AUTOREPEAT_EN enables hold-to-repeat
// on btn_inc.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       sel_alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic [1:0] edit_digit
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            set_p, inc_p;
  state_e          state_q, state_d;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic            target_q, target_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_edit, timeout;
  logic            load_time_q, load_alarm_q, editing_q;
  logic [1:0]      edit_digit_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_set_db (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (btn_set),
    .press_o(set_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_inc_db (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (btn_inc),
    .press_o(inc_p)
  );

  assign in_edit = (state_q != S_IDLE) && (state_q != S_COMMIT);
  assign timeout = in_edit && !set_p && !inc_p &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Next state and digit updates; a set pulse always beats a same-cycle inc.
  always_comb begin
    state_d  = state_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    target_d = target_q;
    to_cnt_d = (in_edit && !set_p && !inc_p) ? to_cnt_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: begin
        if (set_p) begin
          target_d = sel_alarm;
          h1_d     = '0;
          h0_d     = '0;
          m1_d     = '0;
          m0_d     = '0;
          state_d  = S_EDIT_H1;
        end
      end
      S_EDIT_H1: begin
        if (set_p) begin
          state_d = S_EDIT_H0;
        end else if (inc_p) begin
          h1_d = (h1_q >= H1_MAX) ? 2'd0 : h1_q + 2'd1;
          // Keep the hour legal when the tens digit moves onto 2.
          if (h1_d == H1_MAX && h0_q > H0_MAX_20) h0_d = H0_MAX_20;
        end
      end
      S_EDIT_H0: begin
        if (set_p) state_d = S_EDIT_M1;
        else if (inc_p) h0_d = bcd_bump(h0_q, (h1_q == H1_MAX) ? H0_MAX_20 : H0_MAX);
      end
      S_EDIT_M1: begin
        if (set_p) state_d = S_EDIT_M0;
        else if (inc_p) m1_d = bcd_bump(m1_q, M1_MAX);
      end
      S_EDIT_M0: begin
        if (set_p) state_d = S_COMMIT;
        else if (inc_p) m0_d = bcd_bump(m0_q, M0_MAX);
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  // State, digit, target and timeout registers plus registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      h1_q         <= '0;
      h0_q         <= '0;
      m1_q         <= '0;
      m0_q         <= '0;
      target_q     <= 1'b0;
      to_cnt_q     <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      editing_q    <= 1'b0;
      edit_digit_q <= '0;
    end else begin
      state_q      <= state_d;
      h1_q         <= h1_d;
      h0_q         <= h0_d;
      m1_q         <= m1_d;
      m0_q         <= m0_d;
      target_q     <= target_d;
      to_cnt_q     <= to_cnt_d;
      load_time_q  <= (state_d == S_COMMIT) && !target_d;
      load_alarm_q <= (state_d == S_COMMIT) && target_d;
      editing_q    <= (state_d != S_IDLE) && (state_d != S_COMMIT);
      edit_digit_q <= digit_of(state_d);
    end
  end

  assign H_in1      = h1_q;
  assign H_in0      = h0_q;
  assign M_in1      = m1_q;
  assign M_in0      = m0_q;
  assign load_time  = load_time_q;
  assign load_alarm = load_alarm_q;
  assign editing    = editing_q;
  assign edit_digit = edit_digit_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized
// entry sequences checked against an arithmetic model of the entry rules.
module tb_time_set_ctrl;

  localparam int DEB  = 4;
  localparam int TO   = 200;
  localparam int REP  = 8;
  localparam int HOLD = 12;

  logic       clock = 1'b0, reset = 1'b0;
  logic       btn_set = 1'b0, btn_inc = 1'b0, sel_alarm = 1'b0;
  logic [1:0] H_in1, edit_digit;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       load_time, load_alarm, editing;

  int n_cmp = 0, n_fail = 0;
  int n_lt = 0, n_la = 0, n_both = 0, n_long = 0;
  logic prev_lt = 1'b0, prev_la = 1'b0;
  logic [13:0] strobe_digits = '0;

  // reference model: digits, active digit (-1 = not editing), target, strobes
  int m_h1 = 0, m_h0 = 0, m_m1 = 0, m_m0 = 0, m_dig = -1;
  bit m_tgt = 1'b0;
  int e_lt = 0, e_la = 0;

  always #5 clock = ~clock;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_set   (btn_set),
    .btn_inc   (btn_inc),
    .sel_alarm (sel_alarm),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .load_time (load_time),
    .load_alarm(load_alarm),
    .editing   (editing),
    .edit_digit(edit_digit)
  );

  // strobe monitor
  always @(negedge clock) begin
    if (load_time) n_lt++;
    if (load_alarm) n_la++;
    if (load_time && load_alarm) n_both++;
    if ((load_time && prev_lt) || (load_alarm && prev_la)) n_long++;
    if (load_time || load_alarm) strobe_digits = {H_in1, H_in0, M_in1, M_in0};
    prev_lt = load_time;
    prev_la = load_alarm;
  end

  function automatic logic [13:0] model_vec();
    return {2'(m_h1), 4'(m_h0), 4'(m_m1), 4'(m_m0)};
  endfunction

  function automatic logic [2:0] model_status();
    return (m_dig >= 0) ? {1'b1, 2'(m_dig)} : 3'b000;
  endfunction

  // Press-and-release of the raw buttons, then apply the entry rules to the model.
  task automatic step(input bit s, input bit i);
    btn_set = s;
    btn_inc = i;
    repeat (HOLD) @(negedge clock);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clock);
    if (s) begin
      if (m_dig < 0) begin
        m_tgt = sel_alarm;
        m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0;
        m_dig = 0;
      end else if (m_dig < 3) begin
        m_dig++;
      end else begin
        if (m_tgt) e_la++; else e_lt++;
        m_dig = -1;
      end
    end else if (i && m_dig >= 0) begin
      case (m_dig)
        0: begin
          m_h1 = (m_h1 + 1) % 3;
          if (m_h1 == 2 && m_h0 > 3) m_h0 = 3;
        end
        1: m_h0 = (m_h0 + 1) % ((m_h1 == 2) ? 4 : 10);
        2: m_m1 = (m_m1 + 1) % 6;
        default: m_m0 = (m_m0 + 1) % 10;
      endcase
    end
  endtask

  task automatic steps(input bit s, input bit i, input int n);
    for (int k = 0; k < n; k++) step(s, i);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if ({H_in1, H_in0, M_in1, M_in0, load_time, load_alarm, editing, edit_digit} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h want 0",
               {H_in1, H_in0, M_in1, M_in0, load_time, load_alarm, editing, edit_digit});
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    $display("reset: outputs %h", {H_in1, H_in0, M_in1, M_in0});
  endtask

  task automatic test_reset_mid_edit();
    int lt0, la0;
    sel_alarm = 1'b0;
    step(1, 0); step(0, 1); step(1, 0); steps(0, 1, 2); step(1, 0);
    n_cmp++;
    if ({editing, edit_digit, H_in1, H_in0} !== {1'b1, 2'd2, 2'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL mid_edit_setup: got ed=%b dig=%0d H=%0d%0d want ed=1 dig=2 H=12",
               editing, edit_digit, H_in1, H_in0);
    end
    lt0 = n_lt; la0 = n_la;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({editing, edit_digit, H_in1, H_in0, M_in1, M_in0, load_time, load_alarm} !== 18'd0) begin
      n_fail++;
      $display("FAIL mid_edit_reset: got ed=%b dig=%0d digits=%h want all 0",
               editing, edit_digit, {H_in1, H_in0, M_in1, M_in0});
    end
    reset = 1'b1;
    m_dig = -1; m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({n_lt, n_la} !== {lt0, la0}) begin
      n_fail++;
      $display("FAIL mid_edit_strobe: got lt=%0d la=%0d want lt=%0d la=%0d", n_lt, n_la, lt0, la0);
    end
    $display("reset_mid_edit: editing=%b digits=%h", editing, {H_in1, H_in0, M_in1, M_in0});
  endtask

  task automatic test_time_entry();
    int lt0, la0;
    lt0 = n_lt; la0 = n_la;
    sel_alarm = 1'b0;
    step(1, 0); steps(0, 1, 2); step(1, 0); steps(0, 1, 3);
    step(1, 0); steps(0, 1, 4); step(1, 0); steps(0, 1, 5); step(1, 0);
    n_cmp++;
    if (n_lt - lt0 !== 1 || n_la !== la0) begin
      n_fail++;
      $display("FAIL time_strobe: got lt+%0d la+%0d want lt+1 la+0", n_lt - lt0, n_la - la0);
    end
    n_cmp++;
    if (strobe_digits !== {2'd2, 4'd3, 4'd4, 4'd5}) begin
      n_fail++;
      $display("FAIL time_digits: got %h want 2345 (packed)", strobe_digits);
    end
    n_cmp++;
    if ({n_long, n_both} !== {32'd0, 32'd0} || editing !== 1'b0) begin
      n_fail++;
      $display("FAIL time_strobe_shape: got long=%0d both=%0d editing=%b want 0 0 0",
               n_long, n_both, editing);
    end
    $display("time_entry: strobe digits %h", strobe_digits);
  endtask

  task automatic test_alarm_entry();
    int la0;
    la0 = n_la;
    sel_alarm = 1'b1;
    step(1, 0); steps(0, 1, 2); step(1, 0); steps(0, 1, 3);
    sel_alarm = 1'b0;  // target was latched at edit start
    steps(1, 0, 3);
    n_cmp++;
    if (n_la - la0 !== 1 || n_lt !== e_lt) begin
      n_fail++;
      $display("FAIL alarm_strobe: got la+%0d lt=%0d want la+1 lt=%0d", n_la - la0, n_lt, e_lt);
    end
    n_cmp++;
    if (strobe_digits !== {2'd2, 4'd3, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL alarm_digits: got %h want 2300 (packed)", strobe_digits);
    end
    repeat (10) @(negedge clock);
    n_cmp++;
    if ({H_in1, H_in0, M_in1, M_in0} !== model_vec()) begin
      n_fail++;
      $display("FAIL digits_hold: got %h want %h", {H_in1, H_in0, M_in1, M_in0}, model_vec());
    end
    $display("alarm_entry: strobe digits %h", strobe_digits);
  endtask

  task automatic test_wrap();
    sel_alarm = 1'b0;
    step(1, 0); steps(0, 1, 2); step(1, 0); steps(0, 1, 4);
    n_cmp++;
    if ({H_in1, H_in0} !== {2'd2, 4'd0}) begin
      n_fail++;
      $display("FAIL h0_wrap_20: got H=%0d%0d want 20", H_in1, H_in0);
    end
    step(1, 0); steps(0, 1, 6);
    n_cmp++;
    if ({edit_digit, M_in1} !== {2'd2, 4'd0}) begin
      n_fail++;
      $display("FAIL m1_wrap: got dig=%0d M1=%0d want dig=2 M1=0", edit_digit, M_in1);
    end
    step(1, 0); steps(0, 1, 11);
    n_cmp++;
    if (M_in0 !== 4'd1) begin
      n_fail++;
      $display("FAIL m0_wrap: got %0d want 1", M_in0);
    end
    step(1, 0);
    $display("wrap: final digits %h", {H_in1, H_in0, M_in1, M_in0});
  endtask

  task automatic test_glitch_and_simultaneous();
    sel_alarm = 1'b0;
    step(1, 0); step(0, 1);
    btn_inc = 1'b1;
    repeat (3) @(negedge clock);
    btn_inc = 1'b0;
    repeat (20) @(negedge clock);
    n_cmp++;
    if ({H_in1, H_in0, M_in1, M_in0} !== model_vec()) begin
      n_fail++;
      $display("FAIL glitch: got %h want %h", {H_in1, H_in0, M_in1, M_in0}, model_vec());
    end
    step(1, 1);
    n_cmp++;
    if ({editing, edit_digit, H_in1, H_in0, M_in1, M_in0} !== {model_status(), model_vec()}) begin
      n_fail++;
      $display("FAIL set_inc_same_cycle: got %h want %h",
               {editing, edit_digit, H_in1, H_in0, M_in1, M_in0}, {model_status(), model_vec()});
    end
    steps(1, 0, 3);
    $display("glitch_simul: digits %h", {H_in1, H_in0, M_in1, M_in0});
  endtask

  task automatic test_timeout();
    int lt0, la0, w;
    lt0 = n_lt; la0 = n_la;
    sel_alarm = 1'b1;
    step(1, 0); step(0, 1);
    repeat (100) @(negedge clock);
    n_cmp++;
    if (editing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got editing=%b want 1", editing);
    end
    w = 0;
    while (editing === 1'b1 && w < 400) begin
      @(negedge clock);
      w++;
    end
    n_cmp++;
    if (w < 70 || w > 100) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d extra cycles want 70..100", w);
    end
    m_dig = -1;
    n_cmp++;
    if ({n_lt, n_la} !== {lt0, la0} ||
        {H_in1, H_in0, M_in1, M_in0} !== model_vec()) begin
      n_fail++;
      $display("FAIL timeout_abort: got lt=%0d la=%0d digits=%h want lt=%0d la=%0d digits=%h",
               n_lt, n_la, {H_in1, H_in0, M_in1, M_in0}, lt0, la0, model_vec());
    end
    $display("timeout: aborted after %0d extra cycles", w);
  endtask

  task automatic test_random_entries();
    for (int e = 0; e < 6; e++) begin
      sel_alarm = 1'($urandom_range(0, 1));
      step(1, 0);
      for (int d = 0; d < 4; d++) begin
        int n;
        n = $urandom_range(0, 12);
        for (int k = 0; k < n; k++) begin
          step(0, 1);
          n_cmp++;
          if ({editing, edit_digit, H_in1, H_in0, M_in1, M_in0} !== {model_status(), model_vec()}) begin
            n_fail++;
            $display("FAIL rand_inc: got %h want %h",
                     {editing, edit_digit, H_in1, H_in0, M_in1, M_in0}, {model_status(), model_vec()});
          end
        end
        step(1, 1'($urandom_range(0, 1)));
        n_cmp++;
        if ({editing, edit_digit, n_lt, n_la} !== {model_status(), e_lt, e_la}) begin
          n_fail++;
          $display("FAIL rand_advance: got st=%b lt=%0d la=%0d want st=%b lt=%0d la=%0d",
                   {editing, edit_digit}, n_lt, n_la, model_status(), e_lt, e_la);
        end
      end
      n_cmp++;
      if (strobe_digits !== model_vec()) begin
        n_fail++;
        $display("FAIL rand_commit_digits: got %h want %h", strobe_digits, model_vec());
      end
      $display("random entry %0d: target=%0d digits %h", e, m_tgt, strobe_digits);
    end
  endtask

  task automatic test_hold_inc();
    int t_chg[$];
    logic [3:0] last;
    sel_alarm = 1'b0;
    step(1, 0); steps(1, 0, 3);
    last = M_in0;
    btn_inc = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (M_in0 !== last) t_chg.push_back(c);
      last = M_in0;
    end
    btn_inc = 1'b0;
    for (int c = 100; c < 130; c++) begin
      @(negedge clock);
      if (M_in0 !== last) t_chg.push_back(c);
      last = M_in0;
    end
`ifdef TIME_SET_AUTOREPEAT_EN
    n_cmp++;
    if (t_chg.size() < 9 || t_chg.size() > 11) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d increments want 9..11", t_chg.size());
    end else begin
      n_cmp++;
      if (t_chg[1] - t_chg[0] !== 4 * REP || t_chg[2] - t_chg[1] !== REP) begin
        n_fail++;
        $display("FAIL repeat_spacing: got %0d,%0d want %0d,%0d",
                 t_chg[1] - t_chg[0], t_chg[2] - t_chg[1], 4 * REP, REP);
      end
    end
`else
    n_cmp++;
    if (t_chg.size() !== 1) begin
      n_fail++;
      $display("FAIL single_inc_per_press: got %0d increments want 1", t_chg.size());
    end
`endif
    m_m0 = (m_m0 + t_chg.size()) % 10;
    n_cmp++;
    if (M_in0 !== 4'(m_m0)) begin
      n_fail++;
      $display("FAIL hold_value: got %0d want %0d", M_in0, m_m0);
    end
    step(1, 0);
    $display("hold_inc: %0d increments, M0=%0d", t_chg.size(), M_in0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_mid_edit();
    test_time_entry();
    test_alarm_entry();
    test_wrap();
    test_glitch_and_simultaneous();
    test_timeout();
    test_random_entries();
    test_hold_inc();
    n_cmp++;
    if ({n_both, n_long, n_lt, n_la} !== {32'd0, 32'd0, e_lt, e_la}) begin
      n_fail++;
      $display("FAIL strobe_totals: got both=%0d long=%0d lt=%0d la=%0d want 0 0 %0d %0d",
               n_both, n_long, n_lt, n_la, e_lt, e_la);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
